// File: rtl/modexp_seq.sv
// Sequential modular exponentiator: res = a^e mod n using right-to-left
// square-and-multiply over one shared Montgomery multiplier and one reducer.

// Montgomery reduction: r = t * R^-1 mod n, with R = 2^LEN and t < n*R
module mont_redc #(
   parameter int unsigned LEN = 2048
) (
   input  logic [2*LEN-1:0] t,
   input  logic [LEN-1:0]   n,
   input  logic [LEN-1:0]   n_prime,
   output logic [LEN-1:0]   r
);
   localparam int unsigned TW = 2 * LEN + 1;
   localparam int unsigned QW = LEN + 1;

   logic [LEN-1:0] m;
   logic [TW-1:0]  s;
   logic [QW-1:0]  q;

   // (t + m*n) is divisible by R; the quotient is below 2n, so one subtraction suffices
   always_comb begin
      m = LEN'(t[LEN-1:0] * n_prime);
      s = TW'(t) + TW'(m) * TW'(n);
      q = QW'(s >> LEN);
      r = (q >= QW'(n)) ? LEN'(q - QW'(n)) : q[LEN-1:0];
   end
endmodule

// Montgomery product: r = x * y * R^-1 mod n
module mont_mul #(
   parameter int unsigned LEN = 2048
) (
   input  logic [LEN-1:0] x,
   input  logic [LEN-1:0] y,
   input  logic [LEN-1:0] n,
   input  logic [LEN-1:0] n_prime,
   output logic [LEN-1:0] r
);
   localparam int unsigned PW = 2 * LEN;

   logic [PW-1:0] p;

   // Full-width product fed to the reducer
   always_comb begin
      p = PW'(x) * PW'(y);
   end

   mont_redc #(.LEN(LEN)) u_redc (
      .t       (p),
      .n       (n),
      .n_prime (n_prime),
      .r       (r)
   );
endmodule

module modexp_seq #(
   parameter int unsigned LEN     = 2048,
   parameter int unsigned EXP_LEN = 17
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [LEN-1:0]     a,
   input  logic [EXP_LEN-1:0] e,
   input  logic [LEN-1:0]     n,
   input  logic [LEN-1:0]     n_prime,
   input  logic [LEN-1:0]     r2_mod_n,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [LEN-1:0]     res,
   output logic               busy
);
   localparam int unsigned PW = 2 * LEN;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CONV  = 3'd1;
   localparam logic [2:0] S_MUL   = 3'd2;
   localparam logic [2:0] S_SQR   = 3'd3;
   localparam logic [2:0] S_FINAL = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   logic [2:0]         state;
   logic [2:0]         next_state;
   logic [LEN-1:0]     a_reg;
   logic [LEN-1:0]     n_reg;
   logic [LEN-1:0]     np_reg;
   logic [LEN-1:0]     r2_reg;
   logic [EXP_LEN-1:0] exp_reg;
   logic [EXP_LEN-1:0] exp_shift_c;
   logic [LEN-1:0]     base_bar;
   logic [LEN-1:0]     acc_bar;
   logic [LEN-1:0]     mul_x_c;
   logic [LEN-1:0]     mul_y_c;
   logic [LEN-1:0]     mul_r_c;
   logic [PW-1:0]      redc_t_c;
   logic [LEN-1:0]     redc_r_c;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; SQR decides on the already-shifted exponent
   always_comb begin
      next_state  = state;
      exp_shift_c = exp_reg >> 1;
      case (state)
         S_IDLE: begin
            if (in_valid) begin
               next_state = S_CONV;
            end
         end
         S_CONV: begin
            if (exp_reg == '0) begin
               next_state = S_FINAL;
            end else if (exp_reg[0]) begin
               next_state = S_MUL;
            end else begin
               next_state = S_SQR;
            end
         end
         S_MUL: begin
            next_state = S_SQR;
         end
         S_SQR: begin
            if (exp_shift_c == '0) begin
               next_state = S_FINAL;
            end else if (exp_shift_c[0]) begin
               next_state = S_MUL;
            end else begin
               next_state = S_SQR;
            end
         end
         S_FINAL: begin
            next_state = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               next_state = S_IDLE;
            end
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   // Shared multiplier / reducer operand selection by state
   always_comb begin
      mul_x_c  = a_reg;
      mul_y_c  = r2_reg;
      redc_t_c = PW'(r2_reg);
      case (state)
         S_MUL: begin
            mul_x_c = acc_bar;
            mul_y_c = base_bar;
         end
         S_SQR: begin
            mul_x_c = base_bar;
            mul_y_c = base_bar;
         end
         default: begin
            mul_x_c = a_reg;
            mul_y_c = r2_reg;
         end
      endcase
      if (state == S_FINAL) begin
         redc_t_c = PW'(acc_bar);
      end
   end

   mont_mul #(.LEN(LEN)) u_mul (
      .x       (mul_x_c),
      .y       (mul_y_c),
      .n       (n_reg),
      .n_prime (np_reg),
      .r       (mul_r_c)
   );

   mont_redc #(.LEN(LEN)) u_redc (
      .t       (redc_t_c),
      .n       (n_reg),
      .n_prime (np_reg),
      .r       (redc_r_c)
   );

   // Operand capture and square-and-multiply datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg    <= '0;
         n_reg    <= '0;
         np_reg   <= '0;
         r2_reg   <= '0;
         exp_reg  <= '0;
         base_bar <= '0;
         acc_bar  <= '0;
         res      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  a_reg   <= a;
                  n_reg   <= n;
                  np_reg  <= n_prime;
                  r2_reg  <= r2_mod_n;
                  exp_reg <= e;
               end
            end
            S_CONV: begin
               base_bar <= mul_r_c;
               acc_bar  <= redc_r_c;
            end
            S_MUL: begin
               acc_bar <= mul_r_c;
            end
            S_SQR: begin
               base_bar <= mul_r_c;
               exp_reg  <= exp_shift_c;
            end
            S_FINAL: begin
               res <= redc_r_c;
            end
            default: begin
            end
         endcase
      end
   end

   // Handshake and status outputs registered from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         in_ready  <= (next_state == S_IDLE);
         out_valid <= (next_state == S_DONE);
         busy      <= (next_state != S_IDLE);
      end
   end
endmodule

// File: tb/tb_modexp_seq.sv
// Bench for modexp_seq at LEN=8: directed literal jobs, mid-job reset, and
// randomized jobs checked every cycle against a latency/arithmetic model.
module tb_modexp_seq;
   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] e;
   logic [7:0] n;
   logic [7:0] n_prime;
   logic [7:0] r2_mod_n;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] res;
   logic       busy;

   int n_cmp = 0;
   int n_bad = 0;

   // Model state: idle flag, edges remaining until out_valid, pending and last result
   bit         m_idle = 1'b1;
   int         m_cnt  = 0;
   logic [7:0] m_res  = 8'd0;
   logic [7:0] m_last = 8'd0;

   modexp_seq #(.LEN(8), .EXP_LEN(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .e         (e),
      .n         (n),
      .n_prime   (n_prime),
      .r2_mod_n  (r2_mod_n),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .res       (res),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] modexp(input int ba, input int ex, input int md);
      longint r;
      r = 1 % md;
      for (int i = 0; i < ex; i++) r = (r * ba) % md;
      return 8'(r);
   endfunction

   function automatic int lat_of(input logic [7:0] ex);
      int bl;
      bl = 0;
      for (int i = 0; i < 8; i++) if (ex[i]) bl = i + 1;
      return 2 + bl + $countones(ex);
   endfunction

   // Behavioural model: captures a job when idle, counts down its latency, then waits for out_ready
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_idle <= 1'b1;
         m_cnt  <= 0;
         m_last <= 8'd0;
      end else if (m_idle) begin
         if (in_valid) begin
            m_idle <= 1'b0;
            m_cnt  <= lat_of(e);
            m_res  <= modexp(int'(a), int'(e), int'(n));
         end
      end else if (m_cnt > 0) begin
         m_cnt <= m_cnt - 1;
      end else if (out_ready) begin
         m_idle <= 1'b1;
         m_last <= m_res;
      end
   end

   // Per-cycle comparison against the model, mid-cycle
   always @(negedge clk) begin
      chk("in_ready", int'(in_ready), int'(m_idle));
      chk("busy", int'(busy), int'(!m_idle));
      chk("out_valid", int'(out_valid), int'(!m_idle && m_cnt == 0));
      if (!m_idle && m_cnt == 0) chk("res_valid", int'(res), int'(m_res));
      else if (m_idle) chk("res_idle", int'(res), int'(m_last));
   end

   // One job: present operands, measure latency, optionally stall out_ready
   task automatic run_job(input logic [7:0] ta, input logic [7:0] te, input logic [7:0] tn,
                          input logic [7:0] tnp, input logic [7:0] tr2, input int stall,
                          input bit hold_ready, input bit pulse,
                          output logic [7:0] got, output int lat);
      int w;
      w = 0;
      out_ready = hold_ready;
      @(negedge clk);
      while (!in_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) chk("accept_timeout", 0, 1);
      a = ta; e = te; n = tn; n_prime = tnp; r2_mod_n = tr2;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = 8'($urandom); e = 8'($urandom); n = 8'($urandom);
      lat = -1;
      for (int i = 1; i <= 300; i++) begin
         if (pulse && i == 3) in_valid = 1'b1;
         if (pulse && i == 4) in_valid = 1'b0;
         @(posedge clk);
         #1;
         if (out_valid) begin
            lat = i;
            break;
         end
      end
      if (lat < 0) chk("done_timeout", 0, 1);
      got = res;
      for (int i = 0; i < stall; i++) begin
         @(posedge clk);
         #1;
         chk("hold_valid", int'(out_valid), 1);
         chk("hold_res", int'(res), int'(got));
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("drop_valid", int'(out_valid), 0);
      chk("ready_after", int'(in_ready), 1);
      out_ready = hold_ready;
   endtask

   logic [7:0] got;
   int         lat;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; e = '0; n = '0; n_prime = '0; r2_mod_n = '0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_res", int'(res), 0);

      run_job(8'd88, 8'd7, 8'd187, 8'd141, 8'd86, 0, 1'b1, 1'b0, got, lat);
      chk("t2_res", int'(got), 11);
      chk("t2_lat", lat, 8);

      run_job(8'd11, 8'd23, 8'd187, 8'd141, 8'd86, 5, 1'b0, 1'b1, got, lat);
      chk("t3_res", int'(got), 88);
      chk("t3_lat", lat, 11);

      run_job(8'd5, 8'd0, 8'd187, 8'd141, 8'd86, 0, 1'b0, 1'b0, got, lat);
      chk("t4a_res", int'(got), 1);
      chk("t4a_lat", lat, 2);
      run_job(8'd0, 8'd3, 8'd187, 8'd141, 8'd86, 1, 1'b0, 1'b0, got, lat);
      chk("t4b_res", int'(got), 0);
      chk("t4b_lat", lat, 6);

      // Reset during MUL of an e=23 job (CONV after accept, MUL one edge later)
      @(negedge clk);
      a = 8'd11; e = 8'd23; n = 8'd187; n_prime = 8'd141; r2_mod_n = 8'd86;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_in_ready", int'(in_ready), 1);
      chk("t5_out_valid", int'(out_valid), 0);
      chk("t5_busy", int'(busy), 0);
      chk("t5_res", int'(res), 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      begin
         int seen;
         seen = 0;
         repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
         end
         chk("t5_no_stray_valid", seen, 0);
      end
      run_job(8'd88, 8'd7, 8'd187, 8'd141, 8'd86, 0, 1'b1, 1'b0, got, lat);
      chk("t5_after_res", int'(got), 11);

      // Randomized jobs over random odd moduli
      for (int j = 0; j < 40; j++) begin
         int tn, tnp, ta, te;
         tn = 2 * $urandom_range(127, 1) + 1;
         tnp = 0;
         for (int x = 0; x < 256; x++) if (((tn * x) & 255) == 255) tnp = x;
         ta = $urandom_range(tn - 1, 0);
         te = $urandom_range(255, 0);
         begin
            bit hr;
            int st;
            hr = 1'($urandom);
            st = hr ? 0 : $urandom_range(3, 0);
            repeat ($urandom_range(2, 0)) @(posedge clk);
            run_job(8'(ta), 8'(te), 8'(tn), 8'(tnp), 8'(65536 % tn), st, hr, 1'b0, got, lat);
         end
         chk("rand_res", int'(got), int'(modexp(ta, te, tn)));
         chk("rand_lat", lat, lat_of(8'(te)));
      end

      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
